rtmq_rand_stream: RTL and testbench

RTMQ_RAND_STREAM -- requirements
Module: rtmq_rand_stream

---
 rtl/rtmq_rand_pkg.sv | 43 ++++
 rtl/rtmq_taus3.sv | 80 ++++++++
 rtl/rtmq_rand_stream.sv | 109 ++++++++++
 tb/tb_rtmq_rand_stream.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtmq_rand_pkg.sv
// ============================================================================
// Module  : rtmq_rand_pkg
// Brief   : Shared constants, FSM encoding and default-seed helper for the
//           multi-channel three-component Tausworthe stream generator.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package rtmq_rand_pkg;

  localparam logic [63:0] I_Z1 = 64'h45D0_00FF_FFF0_05FF;
  localparam logic [63:0] I_Z2 = 64'hFFFC_BFFF_D800_0680;
  localparam logic [63:0] I_Z3 = 64'hFFDA_3500_00FE_95FF;

  // Golden-ratio spread keeps per-channel default seeds decorrelated.
  localparam logic [63:0] c_spread_mul = 64'h9E37_79B9_7F4A_7C15;

  localparam logic [1:0] c_sel_z1   = 2'd0;
  localparam logic [1:0] c_sel_z2   = 2'd1;
  localparam logic [1:0] c_sel_z3   = 2'd2;
  localparam logic [1:0] c_sel_none = 2'd3;

  localparam int unsigned c_cnt_w = 8;

  typedef enum logic [0:0] {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [63:0] default_seed(input int unsigned ch, input logic [1:0] sel);
    logic [63:0] spread;
    spread = 64'(ch) * c_spread_mul;
    case (sel)
      c_sel_z1: default_seed = I_Z1 ^ spread;
      c_sel_z2: default_seed = I_Z2 ^ spread;
      c_sel_z3: default_seed = I_Z3 ^ spread;
      default:  default_seed = spread;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtmq_taus3.sv
// ============================================================================
// Module  : rtmq_taus3
// Brief   : One generator channel: three Tausworthe states, zero-guarded seed
//           write and the registered output word.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rtmq_taus3
  import rtmq_rand_pkg::*;
#(
  parameter int unsigned W_OUT  = 32,
  parameter int unsigned CH_IDX = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  input  logic             load_i,
  input  logic             seed_we_i,
  input  logic [1:0]       seed_sel_i,
  input  logic [63:0]      seed_data_i,
  output logic [W_OUT-1:0] data_o
);

  localparam logic [63:0] c_def_z1 = default_seed(CH_IDX, c_sel_z1);
  localparam logic [63:0] c_def_z2 = default_seed(CH_IDX, c_sel_z2);
  localparam logic [63:0] c_def_z3 = default_seed(CH_IDX, c_sel_z3);

  logic [63:0]      z1_q, z1_d, z2_q, z2_d, z3_q, z3_d;
  logic [W_OUT-1:0] data_q, data_d;
  logic [63:0]      w_seed_z1, w_seed_z2, w_seed_z3;

  // An all-zero significant field would lock a component at zero forever.
  assign w_seed_z1 = (seed_data_i[63:1] == '0) ? c_def_z1 : seed_data_i;
  assign w_seed_z2 = (seed_data_i[63:6] == '0) ? c_def_z2 : seed_data_i;
  assign w_seed_z3 = (seed_data_i[63:9] == '0) ? c_def_z3 : seed_data_i;

  always_comb begin
    z1_d   = z1_q;
    z2_d   = z2_q;
    z3_d   = z3_q;
    data_d = data_q;
    if (seed_we_i) begin
      case (seed_sel_i)
        c_sel_z1: z1_d = w_seed_z1;
        c_sel_z2: z2_d = w_seed_z2;
        c_sel_z3: z3_d = w_seed_z3;
        default:  ;
      endcase
    end else begin
      if (load_i) begin
        data_d = z1_q[W_OUT-1:0] ^ z2_q[W_OUT-1:0] ^ z3_q[W_OUT-1:0];
      end
      if (step_i) begin
        z1_d = {z1_q[39:1], z1_q[58:34] ^ z1_q[63:39]};
        z2_d = {z2_q[50:6], z2_q[44:26] ^ z2_q[63:45]};
        z3_d = {z3_q[56:9], z3_q[39:24] ^ z3_q[63:48]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z1_q   <= c_def_z1;
      z2_q   <= c_def_z2;
      z3_q   <= c_def_z3;
      data_q <= '0;
    end else begin
      z1_q   <= z1_d;
      z2_q   <= z2_d;
      z3_q   <= z3_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/rtmq_rand_stream.sv
// ============================================================================
// Module  : rtmq_rand_stream
// Brief   : N_CH independent random-word streams with valid/ready handshake,
//           shared warm-up FSM and runtime reseeding.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rtmq_rand_stream
  import rtmq_rand_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned W_OUT  = 32,
  parameter int unsigned N_WARM = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_wr,
  input  logic [2:0]            seed_ch,
  input  logic [1:0]            seed_sel,
  input  logic [63:0]           seed_data,
  output logic [N_CH*W_OUT-1:0] rnd_data,
  output logic [N_CH-1:0]       rnd_valid,
  input  logic [N_CH-1:0]       rnd_ready,
  output logic                  busy
);

  localparam logic [c_cnt_w-1:0] c_warm_init = c_cnt_w'(N_WARM);

  state_e              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]     valid_q, valid_d;
  logic [N_CH-1:0]     w_step, w_load, w_seed_we;
  logic                w_seed_hit;

  assign w_seed_hit = seed_wr && ({1'b0, seed_ch} < 4'(N_CH)) && (seed_sel != c_sel_none);

  // A seed write freezes every channel for that edge so it wins over any reload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    w_step  = '0;
    w_load  = '0;
    if (w_seed_hit) begin
      state_d = ST_WARM;
      cnt_d   = c_warm_init;
      valid_d = '0;
    end else begin
      case (state_q)
        ST_WARM: begin
          w_step = '1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == c_cnt_w'(1)) begin
            state_d = ST_RUN;
            valid_d = '1;
            w_load  = '1;
          end
        end
        ST_RUN: begin
          w_step  = ~valid_q | rnd_ready;
          w_load  = ~valid_q | rnd_ready;
          valid_d = '1;
        end
        default: begin
          state_d = ST_WARM;
          cnt_d   = c_warm_init;
          valid_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WARM;
      cnt_q   <= c_warm_init;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
    assign w_seed_we[c] = w_seed_hit && (seed_ch == 3'(c));

    rtmq_taus3 #(
      .W_OUT  (W_OUT),
      .CH_IDX (c)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .step_i      (w_step[c]),
      .load_i      (w_load[c]),
      .seed_we_i   (w_seed_we[c]),
      .seed_sel_i  (seed_sel),
      .seed_data_i (seed_data),
      .data_o      (rnd_data[c*W_OUT +: W_OUT])
    );
  end

  assign rnd_valid = valid_q;
  assign busy      = (state_q == ST_WARM);

endmodule

`default_nettype wire

// File: tb/tb_rtmq_rand_stream.sv
// ============================================================================
// Module  : tb_rtmq_rand_stream
// Brief   : Randomised self-checking bench for rtmq_rand_stream.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rtmq_rand_stream;

  localparam int N_CH   = 2;
  localparam int W_OUT  = 32;
  localparam int N_WARM = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  seed_wr = 1'b0;
  logic [2:0]            seed_ch = '0;
  logic [1:0]            seed_sel = '0;
  logic [63:0]           seed_data = '0;
  logic [N_CH*W_OUT-1:0] rnd_data;
  logic [N_CH-1:0]       rnd_valid;
  logic [N_CH-1:0]       rnd_ready = '1;
  logic                  busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: per-channel component states plus the word currently presented.
  logic [63:0]      mz [N_CH][3];
  logic [W_OUT-1:0] md [N_CH];
  logic [N_CH-1:0]  mv;
  bit               m_warm;
  int               m_left;
  logic [W_OUT-1:0] golden [N_CH][8];

  rtmq_rand_stream #(
    .N_CH   (N_CH),
    .W_OUT  (W_OUT),
    .N_WARM (N_WARM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_wr   (seed_wr),
    .seed_ch   (seed_ch),
    .seed_sel  (seed_sel),
    .seed_data (seed_data),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] dflt(input int c, input int k);
    logic [63:0] base;
    base = (k == 0) ? 64'h45D0_00FF_FFF0_05FF :
           (k == 1) ? 64'hFFFC_BFFF_D800_0680 : 64'hFFDA_3500_00FE_95FF;
    return base ^ (64'(c) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  function automatic logic [63:0] tstep(input int k, input logic [63:0] z);
    case (k)
      0:       return ((z >> 1) << 25) | (((z >> 34) ^ (z >> 39)) & 64'h1FF_FFFF);
      1:       return ((z >> 6) << 19) | (((z >> 26) ^ (z >> 45)) & 64'h7_FFFF);
      default: return ((z >> 9) << 16) | (((z >> 24) ^ (z >> 48)) & 64'hFFFF);
    endcase
  endfunction

  function automatic logic [W_OUT-1:0] mword(input int c);
    logic [63:0] x;
    x = mz[c][0] ^ mz[c][1] ^ mz[c][2];
    return x[W_OUT-1:0];
  endfunction

  task automatic madvance(input int c);
    for (int k = 0; k < 3; k++) mz[c][k] = tstep(k, mz[c][k]);
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      for (int k = 0; k < 3; k++) mz[c][k] = dflt(c, k);
      md[c] = '0;
    end
    mv     = '0;
    m_warm = 1'b1;
    m_left = N_WARM;
  endtask

  task automatic model_edge(input logic [N_CH-1:0] rdy, input logic wr, input logic [2:0] ch,
                            input logic [1:0] sel, input logic [63:0] d);
    logic [63:0] v;
    int          ci;
    int          si;
    ci = int'(ch);
    si = int'(sel);
    if (wr && ci < N_CH && si != 3) begin
      v = d;
      if (si == 0 && (d >> 1) == 64'd0) v = dflt(ci, 0);
      if (si == 1 && (d >> 6) == 64'd0) v = dflt(ci, 1);
      if (si == 2 && (d >> 9) == 64'd0) v = dflt(ci, 2);
      mz[ci][si] = v;
      mv         = '0;
      m_warm     = 1'b1;
      m_left     = N_WARM;
    end else if (m_warm) begin
      m_left--;
      for (int c = 0; c < N_CH; c++) begin
        if (m_left == 0) md[c] = mword(c);
        madvance(c);
      end
      if (m_left == 0) begin
        mv     = '1;
        m_warm = 1'b0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (rdy[c]) begin
          md[c] = mword(c);
          madvance(c);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("valid", 64'(rnd_valid), 64'(mv));
    chk("busy", 64'(busy), 64'(m_warm));
    for (int c = 0; c < N_CH; c++) chk($sformatf("data%0d", c), 64'(rnd_data[c*W_OUT +: W_OUT]), 64'(md[c]));
  endtask

  // Called at a falling edge: drive, advance the model, clock, then compare.
  task automatic tick_seed(input logic [N_CH-1:0] rdy, input logic wr, input logic [2:0] ch,
                           input logic [1:0] sel, input logic [63:0] d);
    rnd_ready = rdy;
    seed_wr   = wr;
    seed_ch   = ch;
    seed_sel  = sel;
    seed_data = d;
    model_edge(rdy, wr, ch, sel, d);
    @(posedge clk);
    @(negedge clk);
    seed_wr = 1'b0;
    compare_all();
  endtask

  task automatic tick(input logic [N_CH-1:0] rdy);
    tick_seed(rdy, 1'b0, 3'd0, 2'd0, 64'd0);
  endtask

  task automatic run_golden();
    for (int i = 0; i < N_WARM; i++) tick('1);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) tick('1);
      for (int c = 0; c < N_CH; c++)
        chk($sformatf("gold%0d_%0d", c, j), 64'(rnd_data[c*W_OUT +: W_OUT]), 64'(golden[c][j]));
    end
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 64'(rnd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_data", 64'(rnd_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rand_seed();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 1));
      2:       return 64'($urandom_range(0, 63));
      default: return 64'($urandom_range(0, 511));
    endcase
  endfunction

  initial begin
    logic [63:0]      gz [3];
    logic [W_OUT-1:0] held;

    for (int c = 0; c < N_CH; c++) begin
      for (int k = 0; k < 3; k++) gz[k] = dflt(c, k);
      for (int s = 0; s < N_WARM - 1; s++)
        for (int k = 0; k < 3; k++) gz[k] = tstep(k, gz[k]);
      for (int j = 0; j < 8; j++) begin
        golden[c][j] = W_OUT'(gz[0] ^ gz[1] ^ gz[2]);
        for (int k = 0; k < 3; k++) gz[k] = tstep(k, gz[k]);
      end
    end

    // Power-up reset and the basic warm-up / golden sequence.
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    run_golden();

    // Backpressure on channel 0 only.
    held = rnd_data[W_OUT-1:0];
    for (int i = 0; i < 10; i++) begin
      tick(2'b10);
      chk("bp_hold", 64'(rnd_data[W_OUT-1:0]), 64'(held));
    end
    tick(2'b11);

    for (int i = 0; i < 40; i++) tick(N_CH'($urandom));

    // Zero reseed of ch1 z2 falls back to its default.
    tick_seed(N_CH'($urandom), 1'b1, 3'd1, 2'd1, 64'd0);
    for (int i = 0; i < N_WARM + 6; i++) tick('1);

    // Writes to a missing channel or to selector 3 are ignored.
    tick_seed('1, 1'b1, 3'd5, 2'd0, {$urandom, $urandom});
    tick_seed('1, 1'b1, 3'd0, 2'd3, {$urandom, $urandom});
    tick('1);

    // Reseed coinciding with a handshake, then a restart mid-warm-up.
    tick_seed('1, 1'b1, 3'd0, 2'd2, {$urandom, $urandom});
    tick('1);
    tick('1);
    tick_seed('1, 1'b1, 3'd1, 2'd0, {$urandom, $urandom});
    for (int i = 0; i < N_WARM + 4; i++) tick(N_CH'($urandom));

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 5) == 0)
        tick_seed(N_CH'($urandom), 1'b1, 3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), rand_seed());
      else
        tick(N_CH'($urandom));
    end

    // Reset mid-warm, then mid-run; both must replay the golden sequence.
    tick('1);
    tick('1);
    reset_pulse();
    for (int i = 0; i < 2; i++) tick('1);
    reset_pulse();
    run_golden();
    for (int i = 0; i < 5; i++) tick(N_CH'($urandom));
    reset_pulse();
    run_golden();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
